cmd_sequencer: RTL
==================

Name: cmd_sequencer

Overview:
- Front end between the board buttons/switches and the pe_array command port.
- Conditions the raw buttons (synchronise, debounce, edge detect) and holds the step cadence, which retires the separate Timer.
- Drives exactly one array command per cycle: NOP, STEP or WRITE at the switch-selected cell.
- Counts generations for the LEDs.

Parameters:
- N_PX_BITS, 4, array column address width.
- N_PY_BITS, 4, array row address width.
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before a button level is accepted.
- STEP_PERIOD, 100000000, cycles between repeated STEPs while step is held.
- GEN_BITS, 16, generation counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- step_btn  in  1  raw asynchronous step button.
- write_btn  in  1  raw asynchronous write button.
- sw  in  N_PX_BITS+N_PY_BITS  cell address; x = sw[N_PX_BITS-1:0], y = upper bits.
- array_busy  in  1  pe_array active flag; high while the array is executing a command.
- cmd  out  2  array command: 00 NOP, 01 STEP, 11 WRITE. Code 10 is never driven.
- adr_x  out  N_PX_BITS  write column address.
- adr_y  out  N_PY_BITS  write row address.
- state_in  out  1  value written to the cell; constant 1 for WRITE.
- gen_count  out  GEN_BITS  number of STEPs issued since reset; wraps.
- seq_idle  out  1  high when the FSM is in IDLE.

Behaviour:
- Reset values: cmd=00, adr_x=0, adr_y=0, state_in=0, gen_count=0, seq_idle=1. Debouncer outputs = released (0). Pending flags cleared. Repeat counter = 0.
- Button path:
  - 2-flop synchroniser, then debounce counter, then rising-edge pulse.
  - The accepted level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch restarts the count.
- Requests:
  - step_press (edge) sets step_pend.
  - While debounced step is held, the repeat counter counts to STEP_PERIOD-1, then sets step_pend and wraps to 0. The counter clears on release.
  - write_press sets write_pend.
  - A pend flag that is already set is not double-counted: one pending request per type.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if array_busy=0 and a pend flag is set, choose write over step, then go to ISSUE.
  - ISSUE (1 cycle):
    - cmd = chosen code; clear that pend flag.
    - For WRITE: register adr_x/adr_y from sw in this cycle; state_in=1.
    - For STEP: gen_count += 1, modulo 2^GEN_BITS.
    - Go to WAIT.
  - WAIT: cmd=00. Stay at least 1 cycle, then return to IDLE once array_busy=0.
- cmd is registered and non-NOP for exactly one cycle per request.
- Latency: the first cmd comes 1 cycle after a pend flag is set, when the FSM is IDLE and array_busy=0.
- Simultaneous step and write pending: WRITE first. STEP follows after WAIT, so the cell is written before the generation advances.
- array_busy stuck high: the FSM holds in IDLE or WAIT and requests stay pending. There is no timeout.
- adr_x/adr_y hold their last WRITE value between commands. state_in returns to 0 after ISSUE.
- Synchronous reset mid-operation (any state) returns everything to the reset values on the next edge. Pending requests are lost.

Optional Feature:
- Macro: CMD_SEQ_PATTERN_LOAD_EN.
- Defined:
  - Adds input load_btn (1 bit), conditioned like the other buttons.
  - load_press starts a glider seed at base (bx,by) = sw, latched at the press.
  - Issues 5 WRITEs at offsets (1,0),(2,1),(0,2),(1,2),(2,2). Coordinates wrap modulo 2^N_PX_BITS and 2^N_PY_BITS.
  - Each WRITE uses the ISSUE/WAIT handshake; this adds a LOAD state and a 3-bit index.
  - step and write requests arriving during a load are held pending until it completes. load has the highest priority from IDLE.
  - Further load presses during a load are ignored.
- Undefined: no load_btn port, no LOAD state, no pattern ROM.

Decomposition:
- Package cmd_seq_pkg:
  - cmd_t enum (CMD_NOP=2'b00, CMD_STEP=2'b01, CMD_WRITE=2'b11).
  - seq_state_t enum.
  - Glider offset constant array.
- Sub-module btn_conditioner (sync + debounce + rise pulse; parameter DEBOUNCE_CYCLES; outputs level, rise), one instance per button.

Test Plan (DEBOUNCE_CYCLES=4, STEP_PERIOD=10):
- Reset, then step_btn pulsed high for 20 cycles with array_busy=0 → one STEP at press, then further STEPs every 10 cycles while held. gen_count matches the number of STEPs issued.
- step_btn toggled every 2 cycles for 30 cycles → no cmd, gen_count=0.
- sw=8'hA5, write pressed → exactly one cycle cmd=11, adr_x=5, adr_y=A, state_in=1. sw then changed to 8'h00 → adr_x/adr_y stay 5/A.
- write and step pressed on the same edge → WRITE cycle, then STEP after WAIT.
- array_busy held high for 50 cycles after a STEP → no cmd until it drops, then the pending request issues 1 cycle later. Separately, reset asserted in WAIT → cmd=00, gen_count=0, seq_idle=1 next cycle.
- With CMD_SEQ_PATTERN_LOAD_EN and sw=8'hFF, load pressed → WRITEs at (0,F),(1,0),(F,1),(0,1),(1,1), in that order.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// rtl/cmd_seq_pkg.sv - shared types and glider pattern for cmd_sequencer.
// Optional LOAD state enabled by CMD_SEQ_PATTERN_LOAD_EN.
package cmd_seq_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_WRITE = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
`ifdef CMD_SEQ_PATTERN_LOAD_EN
        , ST_LOAD = 2'd3
`endif
    } seq_state_t;

    // Glider cell offsets from the latched base; entries 5..7 pad the 3-bit index.
    localparam int GLIDER_LEN = 5;
    localparam logic [7:0][1:0] GLIDER_DX = {2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    localparam logic [7:0][1:0] GLIDER_DY = {2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchroniser, debouncer and rising-edge pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            rise_q  <= 1'b0;
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q2;
                rise_q  <= sync_q2;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - button front end issuing NOP/STEP/WRITE to the pe_array.
// Glider pattern load enabled by CMD_SEQ_PATTERN_LOAD_EN.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int N_PX_BITS       = 4,
    parameter int N_PY_BITS       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_PERIOD     = 100000000,
    parameter int GEN_BITS        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           step_btn,
    input  logic                           write_btn,
`ifdef CMD_SEQ_PATTERN_LOAD_EN
    input  logic                           load_btn,
`endif
    input  logic [N_PX_BITS+N_PY_BITS-1:0] sw,
    input  logic                           array_busy,
    output logic [1:0]                     cmd,
    output logic [N_PX_BITS-1:0]           adr_x,
    output logic [N_PY_BITS-1:0]           adr_y,
    output logic                           state_in,
    output logic [GEN_BITS-1:0]            gen_count,
    output logic                           seq_idle
);

    localparam int REP_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(STEP_PERIOD - 1);

    logic step_level, step_rise;
    logic write_level, write_rise;
    logic unused_ok;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .level (step_level),
        .rise  (step_rise)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_write_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (write_btn),
        .level (write_level),
        .rise  (write_rise)
    );

    seq_state_t             state, state_nxt;
    cmd_t                   cmd_q, issue_cmd;
    logic [N_PX_BITS-1:0]   adr_x_q, issue_x;
    logic [N_PY_BITS-1:0]   adr_y_q, issue_y;
    logic                   state_in_q;
    logic [GEN_BITS-1:0]    gen_q;
    logic [REP_W-1:0]       rep_q;
    logic                   rep_fire;
    logic                   step_pend, write_pend;
    logic                   clr_step, clr_write;
    logic                   load_go;
    logic                   load_adv;

`ifdef CMD_SEQ_PATTERN_LOAD_EN
    logic                   load_level, load_rise;
    logic                   load_active;
    logic [2:0]             load_idx;
    logic [N_PX_BITS-1:0]   load_bx;
    logic [N_PY_BITS-1:0]   load_by;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (load_btn),
        .level (load_level),
        .rise  (load_rise)
    );

    assign load_go   = load_active;
    assign unused_ok = ^{write_level, load_level};

    // Base is captured once per seed; presses while a seed is running are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_active <= 1'b0;
            load_idx    <= '0;
            load_bx     <= '0;
            load_by     <= '0;
        end else if (load_rise && !load_active) begin
            load_active <= 1'b1;
            load_idx    <= '0;
            load_bx     <= sw[N_PX_BITS-1:0];
            load_by     <= sw[N_PX_BITS+N_PY_BITS-1:N_PX_BITS];
        end else if (load_adv) begin
            load_idx <= load_idx + 1'b1;
            if (load_idx == 3'(GLIDER_LEN - 1)) begin
                load_active <= 1'b0;
            end
        end
    end
`else
    assign load_go   = 1'b0;
    assign unused_ok = write_level;
`endif

    // The press cycle itself holds the repeat counter at 0 so repeats land
    // exactly STEP_PERIOD cycles after the press-generated STEP request.
    assign rep_fire = step_level && !step_rise && (rep_q == REP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_q      <= '0;
            step_pend  <= 1'b0;
            write_pend <= 1'b0;
        end else begin
            if (!step_level || step_rise || rep_fire) begin
                rep_q <= '0;
            end else begin
                rep_q <= rep_q + 1'b1;
            end
            if (clr_step) begin
                step_pend <= 1'b0;
            end
            if (step_rise || rep_fire) begin
                step_pend <= 1'b1;
            end
            if (clr_write) begin
                write_pend <= 1'b0;
            end
            if (write_rise) begin
                write_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_go) begin
`ifdef CMD_SEQ_PATTERN_LOAD_EN
                    state_nxt = ST_LOAD;
`endif
                end else if (!array_busy && (write_pend || step_pend)) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!array_busy) begin
                    state_nxt = ST_IDLE;
`ifdef CMD_SEQ_PATTERN_LOAD_EN
                    if (load_go) begin
                        state_nxt = ST_LOAD;
                    end
`endif
                end
            end
`ifdef CMD_SEQ_PATTERN_LOAD_EN
            ST_LOAD: begin
                if (!array_busy) begin
                    state_nxt = ST_ISSUE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are decided on the edge entering ISSUE so cmd is valid during ISSUE.
    always_comb begin
        issue_cmd = CMD_NOP;
        issue_x   = adr_x_q;
        issue_y   = adr_y_q;
        clr_step  = 1'b0;
        clr_write = 1'b0;
        load_adv  = 1'b0;
        if (state == ST_IDLE && state_nxt == ST_ISSUE) begin
            if (write_pend) begin
                issue_cmd = CMD_WRITE;
                issue_x   = sw[N_PX_BITS-1:0];
                issue_y   = sw[N_PX_BITS+N_PY_BITS-1:N_PX_BITS];
                clr_write = 1'b1;
            end else begin
                issue_cmd = CMD_STEP;
                clr_step  = 1'b1;
            end
        end
`ifdef CMD_SEQ_PATTERN_LOAD_EN
        if (state == ST_LOAD && state_nxt == ST_ISSUE) begin
            issue_cmd = CMD_WRITE;
            issue_x   = load_bx + N_PX_BITS'(GLIDER_DX[load_idx]);
            issue_y   = load_by + N_PY_BITS'(GLIDER_DY[load_idx]);
            load_adv  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q      <= CMD_NOP;
            adr_x_q    <= '0;
            adr_y_q    <= '0;
            state_in_q <= 1'b0;
            gen_q      <= '0;
        end else begin
            cmd_q      <= issue_cmd;
            state_in_q <= (issue_cmd == CMD_WRITE);
            if (issue_cmd == CMD_WRITE) begin
                adr_x_q <= issue_x;
                adr_y_q <= issue_y;
            end
            if (issue_cmd == CMD_STEP) begin
                gen_q <= gen_q + 1'b1;
            end
        end
    end

    assign cmd       = cmd_q;
    assign adr_x     = adr_x_q;
    assign adr_y     = adr_y_q;
    assign state_in  = state_in_q;
    assign gen_count = gen_q;
    assign seq_idle  = (state == ST_IDLE);

endmodule
